// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module : cpu_ctrl_pkg
// Brief  : Shared types and encodings for the multicycle RISC-V control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] C_OP_LW    = 7'b0000011;
    localparam logic [6:0] C_OP_SW    = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] C_OP_BEQ   = 7'b1100011;
    localparam logic [6:0] C_OP_JAL   = 7'b1101111;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] C_RES_DATA      = 2'b01;
    localparam logic [1:0] C_RES_ALURESULT = 2'b10;

    localparam logic [1:0] C_SRCA_PC    = 2'b00;
    localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] C_SRCA_A     = 2'b10;

    localparam logic [1:0] C_SRCB_RD2  = 2'b00;
    localparam logic [1:0] C_SRCB_IMM  = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR = 2'b10;

    localparam logic [1:0] C_IMM_I = 2'b00;
    localparam logic [1:0] C_IMM_S = 2'b01;
    localparam logic [1:0] C_IMM_B = 2'b10;
    localparam logic [1:0] C_IMM_J = 2'b11;

    // Immediate format depends on the opcode alone, independent of FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            C_OP_SW:  imm_src_of = C_IMM_S;
            C_OP_BEQ: imm_src_of = C_IMM_B;
            C_OP_JAL: imm_src_of = C_IMM_J;
            default:  imm_src_of = C_IMM_I;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module : alu_decoder
// Brief  : Maps ALUOp plus funct fields to the 3-bit ALUControl code.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Only R-type (op5=1) with funct7b5 set is a subtract; addi never is.
    logic w_is_sub;
    assign w_is_sub = op5 & funct7b5;

    always_comb begin
        alu_control = C_ALU_ADD;
        case (alu_op)
            C_ALUOP_ADD: alu_control = C_ALU_ADD;
            C_ALUOP_SUB: alu_control = C_ALU_SUB;
            C_ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = w_is_sub ? C_ALU_SUB : C_ALU_ADD;
                    3'b010:  alu_control = C_ALU_SLT;
                    3'b110:  alu_control = C_ALU_OR;
                    3'b111:  alu_control = C_ALU_AND;
                    default: alu_control = C_ALU_ADD;
                endcase
            end
            default: alu_control = C_ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Moore FSM main control for the multicycle RISC-V datapath.
//          Optional macro CTRL_ILLEGAL_HALT_EN: illegal opcodes halt the core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_eff_state;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_alu_op;

    always_ff @(posedge clk) begin
        if (rst) r_state <= RESET_STATE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    C_OP_LW, C_OP_SW: w_next = S_MEMADR;
                    C_OP_RTYPE:       w_next = S_EXECUTER;
                    C_OP_ITYPE:       w_next = S_EXECUTEI;
                    C_OP_BEQ:         w_next = S_BEQ;
                    C_OP_JAL:         w_next = S_JAL;
`ifdef CTRL_ILLEGAL_HALT_EN
                    default:          w_next = S_HALT;
`else
                    default:          w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (op == C_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
`ifdef CTRL_ILLEGAL_HALT_EN
            S_HALT:     w_next = S_HALT;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // During reset the outputs decode the reset state so the datapath sees
    // stable FETCH selects; the write enables are masked separately below.
    assign w_eff_state = rst ? RESET_STATE : r_state;

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_alu_op    = C_ALUOP_ADD;
        AdrSrc      = 1'b0;
        ResultSrc   = C_RES_ALUOUT;
        ALUSrcA     = C_SRCA_PC;
        ALUSrcB     = C_SRCB_RD2;
        case (w_eff_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                ALUSrcA     = C_SRCA_PC;
                ALUSrcB     = C_SRCB_FOUR;
                ResultSrc   = C_RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = C_SRCA_OLDPC;
                ALUSrcB = C_SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = C_SRCA_A;
                ALUSrcB = C_SRCB_IMM;
            end
            S_MEMREAD: begin
                ResultSrc = C_RES_ALUOUT;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = C_RES_DATA;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                ResultSrc   = C_RES_ALUOUT;
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA  = C_SRCA_A;
                ALUSrcB  = C_SRCB_RD2;
                w_alu_op = C_ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA  = C_SRCA_A;
                ALUSrcB  = C_SRCB_IMM;
                w_alu_op = C_ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc   = C_RES_ALUOUT;
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = C_SRCA_A;
                ALUSrcB   = C_SRCB_RD2;
                w_alu_op  = C_ALUOP_SUB;
                ResultSrc = C_RES_ALUOUT;
                w_branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = C_SRCA_OLDPC;
                ALUSrcB     = C_SRCB_FOUR;
                ResultSrc   = C_RES_ALUOUT;
                w_pc_update = 1'b1;
            end
            default: begin
                w_pc_update = 1'b0;
            end
        endcase
    end

    assign PCWrite   = ~rst & (w_pc_update | (w_branch & zero));
    assign MemWrite  = ~rst & w_mem_write;
    assign IRWrite   = ~rst & w_ir_write;
    assign RegWrite  = ~rst & w_reg_write;
    assign ImmSrc    = imm_src_of(op);
    assign state_dbg = w_eff_state;

`ifdef CTRL_ILLEGAL_HALT_EN
    assign illegal = ~rst & (r_state == S_HALT);
`else
    assign illegal = 1'b0;
`endif

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Directed table-driven bench for multicycle_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4,
    // MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, HALT 11.
    localparam logic [31:0] I_ADDI  = 32'h00600413;
    localparam logic [31:0] I_ADDIB = 32'h40000413;
    localparam logic [31:0] I_ANDI  = 32'h0064F413;
    localparam logic [31:0] I_SLTI  = 32'h0064A413;
    localparam logic [31:0] I_ORI   = 32'h0064E413;
    localparam logic [31:0] I_SUB   = 32'h409409B3;
    localparam logic [31:0] I_ADD   = 32'h00940933;
    localparam logic [31:0] I_LW    = 32'h0004A403;
    localparam logic [31:0] I_SW    = 32'h0084A023;
    localparam logic [31:0] I_BEQ   = 32'h00940463;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_ZERO  = 32'h00000000;

    typedef struct {
        logic [31:0] instr;
        logic        z;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packing: state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
    // ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal.
    function automatic logic [20:0] e(input logic [3:0] st, input logic pcw,
            input logic adr, input logic mw, input logic irw, input logic [1:0] rs,
            input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
            input logic [2:0] alu, input logic rw, input logic ill);
        e = {st, pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill};
    endfunction

    function automatic logic [20:0] fetch_e(input logic [1:0] imm);
        fetch_e = e(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
    endfunction

    function automatic logic [20:0] decode_e(input logic [1:0] imm);
        decode_e = e(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
    endfunction

    function automatic logic [20:0] aluwb_e(input logic [1:0] imm);
        aluwb_e = e(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
    endfunction

    function automatic logic [20:0] execi_e(input logic [2:0] alu);
        execi_e = e(4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0, 0);
    endfunction

    function automatic logic [20:0] execr_e(input logic [2:0] alu);
        execr_e = e(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0, 0);
    endfunction

    // FETCH selects with every enable held low.
    localparam logic [20:0] E_RESET = {4'd0, 4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};

    task automatic add(input logic [31:0] instr, input logic z, input logic [20:0] exp);
        vec_t v;
        v.instr = instr;
        v.z     = z;
        v.exp   = exp;
        vecs.push_back(v);
    endtask

    task automatic apply_check(input logic [31:0] instr, input logic z, input logic r,
                               input logic [20:0] exp, input string name);
        logic [20:0] act;
        @(negedge clk);
        op       = instr[6:0];
        funct3   = instr[14:12];
        funct7b5 = instr[30];
        zero     = z;
        rst      = r;
        #1;
        act = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%06h expected=%06h", name, act, exp);
        end
    endtask

    initial begin
        // addi variants, incl. one with Instr[30]=1 that must still add
        add(I_ADDI, 0, fetch_e(2'b00)); add(I_ADDI, 0, decode_e(2'b00));
        add(I_ADDI, 0, execi_e(3'b000)); add(I_ADDI, 0, aluwb_e(2'b00));
        add(I_ADDIB, 0, fetch_e(2'b00)); add(I_ADDIB, 0, decode_e(2'b00));
        add(I_ADDIB, 0, execi_e(3'b000)); add(I_ADDIB, 0, aluwb_e(2'b00));
        add(I_ANDI, 0, fetch_e(2'b00)); add(I_ANDI, 0, decode_e(2'b00));
        add(I_ANDI, 0, execi_e(3'b010)); add(I_ANDI, 0, aluwb_e(2'b00));
        add(I_SLTI, 0, fetch_e(2'b00)); add(I_SLTI, 0, decode_e(2'b00));
        add(I_SLTI, 0, execi_e(3'b101)); add(I_SLTI, 0, aluwb_e(2'b00));
        add(I_ORI, 0, fetch_e(2'b00)); add(I_ORI, 0, decode_e(2'b00));
        add(I_ORI, 0, execi_e(3'b011)); add(I_ORI, 0, aluwb_e(2'b00));
        // R-type; zero=1 outside BEQ must not reach PCWrite
        add(I_SUB, 1, fetch_e(2'b00)); add(I_SUB, 1, decode_e(2'b00));
        add(I_SUB, 1, execr_e(3'b001)); add(I_SUB, 1, aluwb_e(2'b00));
        add(I_ADD, 0, fetch_e(2'b00)); add(I_ADD, 0, decode_e(2'b00));
        add(I_ADD, 0, execr_e(3'b000)); add(I_ADD, 0, aluwb_e(2'b00));
        // lw: 5 cycles
        add(I_LW, 0, fetch_e(2'b00)); add(I_LW, 0, decode_e(2'b00));
        add(I_LW, 0, e(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0));
        add(I_LW, 0, e(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        add(I_LW, 0, e(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        // sw: 4 cycles
        add(I_SW, 0, fetch_e(2'b01)); add(I_SW, 0, decode_e(2'b01));
        add(I_SW, 0, e(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0));
        add(I_SW, 0, e(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
        // beq taken then not taken
        add(I_BEQ, 1, fetch_e(2'b10)); add(I_BEQ, 1, decode_e(2'b10));
        add(I_BEQ, 1, e(4'd10, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0));
        add(I_BEQ, 0, fetch_e(2'b10)); add(I_BEQ, 0, decode_e(2'b10));
        add(I_BEQ, 0, e(4'd10, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0));
        // jal
        add(I_JAL, 0, fetch_e(2'b11)); add(I_JAL, 0, decode_e(2'b11));
        add(I_JAL, 0, e(4'd9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0));
        add(I_JAL, 0, aluwb_e(2'b11));

        // Reset held for two cycles
        apply_check(I_ZERO, 0, 1, E_RESET, "reset0");
        apply_check(I_ZERO, 1, 1, E_RESET, "reset1");

        foreach (vecs[i])
            apply_check(vecs[i].instr, vecs[i].z, 0, vecs[i].exp, $sformatf("vec%0d", i));

        // Illegal opcode
        apply_check(I_ZERO, 0, 0, fetch_e(2'b00), "ill_fetch");
        apply_check(I_ZERO, 0, 0, decode_e(2'b00), "ill_decode");
`ifdef CTRL_ILLEGAL_HALT_EN
        for (int k = 0; k < 10; k++)
            apply_check(I_ZERO, 1, 0, e(4'd11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1),
                        $sformatf("halt%0d", k));
        apply_check(I_ZERO, 0, 1, E_RESET, "halt_rst");
        apply_check(I_ZERO, 0, 0, fetch_e(2'b00), "halt_release");
`else
        apply_check(I_ZERO, 0, 0, fetch_e(2'b00), "ill_nop_fetch");
`endif
        apply_check(I_ZERO, 0, 0, decode_e(2'b00), "after_ill_decode");

        // Reset mid-instruction (lw in MEMWB): no write enable, then FETCH
        apply_check(I_ZERO, 0, 1, E_RESET, "sync_rst");
        apply_check(I_LW, 0, 0, fetch_e(2'b00), "lw2_fetch");
        apply_check(I_LW, 0, 0, decode_e(2'b00), "lw2_decode");
        apply_check(I_LW, 0, 0, e(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0), "lw2_memadr");
        apply_check(I_LW, 0, 0, e(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), "lw2_memread");
        apply_check(I_LW, 1, 1, E_RESET, "lw2_rst_in_memwb");
        apply_check(I_LW, 0, 0, fetch_e(2'b00), "lw2_restart_fetch");
        apply_check(I_LW, 0, 0, decode_e(2'b00), "lw2_restart_decode");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
